// File: rtl/axi_data_types_pkg.sv
// axi_data_types_pkg: shared AXI3 field types, FSM states and burst helpers
package axi_data_types_pkg;
  typedef logic [0:0]  axi_id;
  typedef logic [31:0] axi_address;
  typedef logic [3:0]  axi_burst_length;
  typedef logic [1:0]  axi_burst_size;
  typedef logic [31:0] axi_data;
  typedef logic [3:0]  axi_strobe;
  typedef logic [1:0]  axi_response;
  localparam axi_response AXI_OKAY        = 2'b00;
  localparam axi_response AXI_SLAVE_ERROR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic [2:0] get_bs(input axi_burst_size size);
    return size == 2'd0 ? 3'd1 : size == 2'd1 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic [4:0] unpack_bl(input axi_burst_length len);
    return {1'b0, len} + 5'd1;
  endfunction
  // Byte lanes a beat may touch: one byte, an aligned halfword, or the whole word
  function automatic axi_strobe lane_mask(input axi_burst_size size, input logic [1:0] lo);
    return size == 2'd0 ? axi_strobe'(4'b0001 << lo) : size == 2'd1 ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/axi3_slave_ram.sv
// axi3_slave_ram: 1W1R word RAM with per-byte write enable and registered read
module axi3_slave_ram #(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);
  logic [31:0] mem [WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi3_slave_mem.sv
// axi3_slave_mem: AXI3 slave memory model with independent write and read burst FSMs
module axi3_slave_mem import axi_data_types_pkg::*; #(
  parameter int ID_W = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [1:0]          AWSIZE,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARSIZE,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS) << 2;
  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    return {1'b0, a - BASE_ADDR} < LIMIT;
  endfunction
  function automatic logic [IDX_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [ID_W-1:0] w_id;
  logic [ADDR_W-1:0] w_addr, r_addr, r_nxt;
  axi_burst_length w_len, r_len;
  axi_burst_size w_size, r_size;
  logic [4:0] w_cnt, r_cnt;
  logic w_err, err_d, w_last;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] ram_q;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign b_hs   = BVALID & BREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign r_hs   = RVALID & RREADY;
  assign w_last = (w_cnt + 5'd1) == unpack_bl(w_len);
  // Burst length alone closes the burst; WLAST only feeds the error flag
  assign err_d  = w_err | (w_hs & (!in_win(w_addr) | (WLAST != w_last)));
  assign r_nxt  = r_addr + ADDR_W'(get_bs(r_size));
  assign RDATA  = (RVALID && RRESP == AXI_OKAY) ? ram_q : '0;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      AWREADY <= awready_d;
      WREADY  <= wready_d;
      BVALID  <= bvalid_d;
      ARREADY <= arready_d;
      RVALID  <= rvalid_d;
    end
  always_comb begin
    w_next = (w_state == W_IDLE && aw_hs) ? W_DATA :
             (w_state == W_DATA && w_hs && w_last) ? W_RESP :
             (w_state == W_RESP && b_hs) ? W_IDLE : w_state;
    r_next = (r_state == R_IDLE && ar_hs) ? R_DATA :
             (r_state == R_DATA && r_hs && RLAST) ? R_IDLE : r_state;
  end
  // Handshake outputs are registered from the next state, so no input reaches a READY combinationally
  always_comb begin
    awready_d = w_next == W_IDLE;
    wready_d  = w_next == W_DATA;
    bvalid_d  = w_next == W_RESP;
    arready_d = r_next == R_IDLE;
    rvalid_d  = r_next == R_DATA;
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      w_id   <= '0;
      w_addr <= '0;
      w_len  <= '0;
      w_size <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
      BID    <= '0;
      BRESP  <= AXI_OKAY;
    end else if (aw_hs) begin
      w_id   <= AWID;
      w_addr <= AWADDR;
      w_len  <= AWLEN;
      w_size <= AWSIZE;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr + ADDR_W'(get_bs(w_size));
      w_cnt  <= w_cnt + 5'd1;
      w_err  <= err_d;
      if (w_last) begin
        BID   <= w_id;
        BRESP <= err_d ? AXI_SLAVE_ERROR : AXI_OKAY;
      end
    end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_cnt  <= '0;
      RID    <= '0;
      RRESP  <= AXI_OKAY;
      RLAST  <= 1'b0;
    end else if (ar_hs) begin
      r_addr <= ARADDR;
      r_len  <= ARLEN;
      r_size <= ARSIZE;
      r_cnt  <= '0;
      RID    <= ARID;
      RRESP  <= in_win(ARADDR) ? AXI_OKAY : AXI_SLAVE_ERROR;
      RLAST  <= ARLEN == 4'd0;
    end else if (r_hs) begin
      r_addr <= r_nxt;
      r_cnt  <= r_cnt + 5'd1;
      RRESP  <= (RLAST || in_win(r_nxt)) ? AXI_OKAY : AXI_SLAVE_ERROR;
      RLAST  <= !RLAST && (r_cnt + 5'd2 == unpack_bl(r_len));
    end
  // The RAM output register only advances on a new beat, which holds RDATA through stalls
  axi3_slave_ram #(.WORDS(MEM_WORDS)) ram (
    .clk  (ACLK),
    .we   (w_hs & in_win(w_addr)),
    .wstrb(WSTRB & lane_mask(w_size, w_addr[1:0])),
    .waddr(word_of(w_addr)),
    .wdata(WDATA),
    .re   (ar_hs | (r_hs & !RLAST)),
    .raddr(word_of(ar_hs ? ARADDR : r_nxt)),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_axi3_slave_mem.sv
// tb_axi3_slave_mem: directed AXI3 bursts checked against a behavioural memory and response model
module tb_axi3_slave_mem;
  localparam int MEM_WORDS = 1024;
  localparam logic [31:0] BASE = 32'h0;
  typedef struct {logic id; logic [31:0] data; logic [1:0] resp; logic last;} rb_t;
  typedef struct {logic id; logic [1:0] resp;} bb_t;
  logic ACLK = 0, ARESET = 1;
  logic [0:0] AWID = 0, ARID = 0, BID, RID;
  logic [31:0] AWADDR = 0, ARADDR = 0, WDATA = 0, RDATA;
  logic [3:0] AWLEN = 0, ARLEN = 0, WSTRB = 0;
  logic [1:0] AWSIZE = 0, ARSIZE = 0, BRESP, RRESP;
  logic AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  rb_t exp_r[$], got_r[$];
  bb_t exp_b[$], got_b[$];
  logic [31:0] mm [MEM_WORDS];
  logic [31:0] wd [16];
  int n_cmp = 0, n_bad = 0;
  logic [35:0] prev_r;
  bit prev_stall = 0;
  axi3_slave_mem #(.ID_W(1), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, got, exp);
    end
  endtask
  function automatic bit in_rng(input logic [31:0] a);
    return a >= BASE && (a - BASE) < 32'(MEM_WORDS * 4);
  endfunction
  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction
  // Outputs are sampled on the falling edge, half a cycle away from the active edge
  always @(negedge ACLK) begin
    if (ARESET) begin
      chk("reset_outputs", {AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID}, 64'h0);
      prev_stall = 0;
    end else begin
      if (BVALID && exp_b.size() == 0) chk("b_spurious", {63'h0, BVALID}, 64'h0);
      else if (BVALID) begin
        chk("b_resp", {BID, BRESP}, {exp_b[0].id, exp_b[0].resp});
        if (BREADY) begin
          got_b.push_back('{id: BID, resp: BRESP});
          void'(exp_b.pop_front());
        end
      end
      if (prev_stall) chk("r_stable_while_stalled", {RVALID, RID, RDATA, RRESP, RLAST}, {1'b1, prev_r});
      prev_stall = RVALID && !RREADY;
      prev_r = {RID, RDATA, RRESP, RLAST};
      if (RVALID && exp_r.size() == 0) chk("r_spurious", {63'h0, RVALID}, 64'h0);
      else if (RVALID) begin
        chk("r_beat", {RID, RDATA, RRESP, RLAST}, {exp_r[0].id, exp_r[0].data, exp_r[0].resp, exp_r[0].last});
        if (RREADY) begin
          got_r.push_back('{id: RID, data: RDATA, resp: RRESP, last: RLAST});
          void'(exp_r.pop_front());
        end
      end
    end
  end
  task automatic hs_wait(input int sel, input string nm);
    logic r;
    for (int k = 0; k < 50; k++) begin
      @(negedge ACLK);
      r = sel == 0 ? AWREADY : sel == 1 ? WREADY : ARREADY;
      @(posedge ACLK);
      #1;
      if (r) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=no handshake required=handshake within 50 cycles", nm);
  endtask
  task automatic wr(input logic id, input logic [31:0] addr, input int len, input logic [1:0] size,
                    input logic [3:0] strb, input int wlast_at, input int abort_after);
    logic [31:0] a;
    bit err;
    int n, lo;
    a = addr;
    err = 0;
    n = nbytes(size);
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWVALID = 1;
    hs_wait(0, "aw_handshake");
    AWVALID = 0;
    chk("wready_after_aw", {AWREADY, WREADY}, 2'b01);
    for (int b = 0; b <= len; b++) begin
      if (b == abort_after) begin
        WVALID = 0;
        WLAST = 0;
        return;
      end
      WDATA = wd[b]; WSTRB = strb; WLAST = (b == wlast_at); WVALID = 1;
      hs_wait(1, "w_handshake");
      if (in_rng(a)) begin
        lo = int'(a[1:0]) / n * n;
        for (int i = lo; i < lo + n; i++)
          if (strb[i]) mm[(a - BASE) >> 2][8*i +: 8] = wd[b][8*i +: 8];
      end else err = 1;
      if ((b == wlast_at) != (b == len)) err = 1;
      a += 32'(n);
    end
    WVALID = 0;
    WLAST = 0;
    exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
  endtask
  task automatic wait_b(input int hold);
    BREADY = 0;
    got_b.delete();
    for (int k = 0; k < 50 && !BVALID; k++) begin @(posedge ACLK); #1; end
    repeat (hold) begin
      @(posedge ACLK);
      #1;
      chk("b_held_while_bready_low", {63'h0, BVALID}, 64'h1);
    end
    BREADY = 1;
    for (int k = 0; k < 50 && exp_b.size() > 0; k++) begin @(posedge ACLK); #1; end
    chk("b_outstanding", exp_b.size(), 0);
    chk("awready_after_b", {63'h0, AWREADY}, 64'h1);
    BREADY = 0;
    exp_b.delete();
  endtask
  task automatic rd(input logic id, input logic [31:0] addr, input int len, input logic [1:0] size, input bit stall);
    logic [31:0] a;
    rb_t e;
    a = addr;
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARVALID = 1;
    hs_wait(2, "ar_handshake");
    ARVALID = 0;
    got_r.delete();
    for (int b = 0; b <= len; b++) begin
      e.id = id;
      e.last = (b == len);
      e.data = in_rng(a) ? mm[(a - BASE) >> 2] : 32'h0;
      e.resp = in_rng(a) ? 2'b00 : 2'b10;
      exp_r.push_back(e);
      a += 32'(nbytes(size));
    end
    for (int k = 0; k < 100 && exp_r.size() > 0; k++) begin
      RREADY = stall ? (k % 2 == 0) : 1'b1;
      @(posedge ACLK);
      #1;
    end
    RREADY = 0;
    chk("r_outstanding", exp_r.size(), 0);
    exp_r.delete();
  endtask
  task automatic pin_r(input string nm, input int i, input logic [31:0] d, input logic [1:0] r, input logic l);
    logic [34:0] g;
    g = '1;
    if (i < got_r.size()) g = {got_r[i].data, got_r[i].resp, got_r[i].last};
    chk(nm, 64'(g), 64'({d, r, l}));
  endtask
  task automatic pin_b(input string nm, input logic id, input logic [1:0] r);
    logic [2:0] g;
    g = '1;
    if (got_b.size() > 0) g = {got_b[0].id, got_b[0].resp};
    chk(nm, 64'(g), 64'({id, r}));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mm[i] = 32'h0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;
    @(posedge ACLK);
    #1;
    chk("ready_after_reset", {AWREADY, ARREADY, WREADY, BVALID, RVALID}, 5'b11000);
    wd[0] = 32'hDEADBEEF;
    wr(1, 32'h10, 0, 2'b10, 4'hF, 0, -1);
    wait_b(0);
    pin_b("single_bresp", 1, 2'b00);
    chk("model_word_10", mm[4], 32'hDEADBEEF);
    rd(1, 32'h10, 0, 2'b10, 0);
    pin_r("single_read", 0, 32'hDEADBEEF, 2'b00, 1);
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    wr(0, 32'h20, 3, 2'b10, 4'hF, 3, -1);
    wait_b(0);
    rd(0, 32'h20, 3, 2'b10, 1);
    for (int i = 0; i < 4; i++) pin_r("incr_read_stalled", i, 32'(i + 1), 2'b00, i == 3);
    wd[0] = 32'h0; wd[1] = 32'h0;
    wr(0, 32'h40, 1, 2'b10, 4'hF, 1, -1);
    wait_b(0);
    wd[0] = 32'h0000AA00; wd[1] = 32'h00BB0000;
    wr(0, 32'h41, 1, 2'b00, 4'hF, 1, -1);
    wait_b(0);
    chk("model_word_40", mm[16], 32'h00BBAA00);
    rd(0, 32'h40, 0, 2'b10, 0);
    pin_r("narrow_byte_write", 0, 32'h00BBAA00, 2'b00, 1);
    wd[0] = 32'hCCDD1122;
    wr(1, 32'h42, 0, 2'b01, 4'hF, 0, -1);
    wait_b(0);
    wd[0] = 32'h11223344;
    wr(1, 32'h44, 0, 2'b10, 4'b0101, 0, -1);
    wait_b(0);
    rd(1, 32'h40, 1, 2'b10, 0);
    pin_r("halfword_write", 0, 32'hCCDDAA00, 2'b00, 0);
    pin_r("wstrb_masked_write", 1, 32'h00220044, 2'b00, 1);
    wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    wr(1, 32'hFFC, 1, 2'b10, 4'hF, 1, -1);
    wait_b(0);
    pin_b("oor_write_bresp", 1, 2'b10);
    rd(1, 32'hFFC, 1, 2'b10, 0);
    pin_r("oor_read_beat0", 0, 32'h11111111, 2'b00, 0);
    pin_r("oor_read_beat1", 1, 32'h0, 2'b10, 1);
    for (int i = 0; i < 4; i++) wd[i] = 32'h50 + 32'(i);
    wr(0, 32'h60, 3, 2'b10, 4'hF, 1, -1);
    wait_b(5);
    pin_b("early_wlast_bresp", 0, 2'b10);
    rd(0, 32'h60, 3, 2'b10, 0);
    for (int i = 0; i < 4; i++) pin_r("early_wlast_data", i, 32'h50 + 32'(i), 2'b00, i == 3);
    for (int i = 0; i < 4; i++) wd[i] = 32'hA1 + 32'(i);
    wr(0, 32'h80, 3, 2'b10, 4'hF, 3, 2);
    ARESET = 1;
    #1;
    chk("async_reset_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 5'b0);
    @(posedge ACLK);
    @(posedge ACLK);
    #1 ARESET = 0;
    @(posedge ACLK);
    #1;
    chk("awready_first_cycle_after_reset", {AWREADY, WREADY}, 2'b10);
    repeat (5) begin
      @(posedge ACLK);
      #1;
      chk("no_b_after_abort", {63'h0, BVALID}, 64'h0);
    end
    rd(0, 32'h80, 1, 2'b10, 0);
    pin_r("partial_write_kept0", 0, 32'hA1, 2'b00, 0);
    pin_r("partial_write_kept1", 1, 32'hA2, 2'b00, 1);
    repeat (3) @(posedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi3_slave_mem.md
Name: axi3_slave_mem

Overview:
- AXI3 slave memory model: the responder end of the DMA master's AXI3 interface.
- Accepts write bursts on AW/W and answers on B; accepts read bursts on AR and returns data on R.
- Backed by an internal word-addressed RAM.
- Sits opposite the DMA master in the block-level testbench and in the integration top, replacing system memory.

Parameters:
- ID_W, 1, ID width (matches package axi_id)
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed 32 in this revision
- MEM_WORDS, 1024, RAM depth in DATA_W words
- BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous reset, active-high
- AWID  in  ID_W  write address ID
- AWADDR  in  ADDR_W  write start byte address
- AWLEN  in  4  beats-1
- AWSIZE  in  2  DMA custom size: 00=8b, 01=16b, 10/11=32b
- AWVALID  in  1
- AWREADY  out  1
- WDATA  in  DATA_W
- WSTRB  in  DATA_W/8
- WLAST  in  1
- WVALID  in  1
- WREADY  out  1
- BID  out  ID_W
- BRESP  out  2
- BVALID  out  1
- BREADY  in  1
- ARID  in  ID_W
- ARADDR  in  ADDR_W
- ARLEN  in  4
- ARSIZE  in  2
- ARVALID  in  1
- ARREADY  out  1
- RID  out  ID_W
- RDATA  out  DATA_W
- RRESP  out  2
- RLAST  out  1
- RVALID  out  1
- RREADY  in  1

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - FSMs to IDLE.
  - RAM contents not reset.
- AWREADY/ARREADY registered; rise the first cycle after ARESET deasserts.
- Transfer occurs on any edge with VALID&READY. No combinational path from any input to any READY.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID/addr/len/size, clear beat count and error flag; AWREADY=0, WREADY=1 next cycle.
  - W_DATA: WREADY=1. Each W handshake applies effective strobe = WSTRB & lane mask to RAM word (addr-BASE_ADDR)>>2.
    - Lane mask derived from size and addr[1:0]: 8b gives 1 lane, 16b gives 2 lanes aligned to addr[1], 32b gives all lanes.
    - Address then increments by 1/2/4 bytes (INCR only; no wrap, no FIXED).
    - Burst ends on beat count == len+1, never on WLAST alone.
    - Error flag set if WLAST is missing on the final beat, if WLAST appears early, or if any beat address falls outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4). Out-of-range beats are not written.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=AXI_SLAVE_ERROR if error flag else AXI_OKAY.
    - BVALID held, with stable BID/BRESP, until BREADY.
    - Next cycle returns to W_IDLE with AWREADY=1.
  - One outstanding write; AW latency to WREADY is 1 cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, latch fields; first beat presented next cycle (RVALID=1, RDATA registered from RAM).
  - R_DATA:
    - RDATA/RRESP/RLAST/RID held stable while RVALID & !RREADY.
    - On handshake, next beat is loaded the following cycle with no bubble; address incremented as for writes.
    - RDATA returns the full word; lanes are not masked.
    - Out-of-range beat returns RDATA=0, RRESP=AXI_SLAVE_ERROR. Other beats return AXI_OKAY.
    - RLAST=1 exactly on beat len+1.
    - After the last handshake, RVALID=0 and ARREADY=1 next cycle.
- Read and write FSMs are independent and may run concurrently.
- Same-cycle write and read beat to the same word: the read returns the pre-write data.
- Address increment wraps modulo 2^ADDR_W; the resulting beat is out of range unless the window covers it.
- ARESET mid-burst aborts both FSMs immediately. No B or R is issued for the aborted burst. Partially written RAM words remain.

Decomposition:
- Shared package (axi_data_types_pkg) holds:
  - axi_id, axi_address, axi_burst_length, axi_burst_size, axi_data, axi_strobe, axi_response
  - get_bs(), unpack_bl()
  - New pure function lane_mask(size, addr[1:0]) returning axi_strobe
- One natural sub-module: axi3_slave_ram, a 1W1R synchronous RAM with per-byte write enable and registered read, MEM_WORDS deep.

Test Plan:
- Single-beat write, AWADDR=0x10, AWLEN=0, size=10, WDATA=0xDEADBEEF, WSTRB=F -> BRESP=OKAY, BID echoed; subsequent read of 0x10 returns 0xDEADBEEF, RLAST=1.
- INCR write, AWADDR=0x20, AWLEN=3, size=10, data 1,2,3,4 -> read ARLEN=3 returns 1,2,3,4 with RLAST on beat 4 only; with RREADY toggled every other cycle, data is held stable while stalled.
- Narrow write, size=00, AWADDR=0x41, AWLEN=1, WSTRB=F, WDATA=0x0000AA00 then 0x00BB0000 -> word 0x40 becomes 0x00BBAA00 from preset 0; other bytes unchanged.
- Out-of-range write at BASE_ADDR+MEM_WORDS*4-4, AWLEN=1 -> first beat written, second discarded, BRESP=SLAVE_ERROR. Read with the same address and length -> second beat RDATA=0, RRESP=SLAVE_ERROR.
- WLAST asserted on beat 2 of an AWLEN=3 burst -> all 4 beats accepted, BRESP=SLAVE_ERROR. BREADY held low 5 cycles -> BVALID/BRESP held stable until it rises.
- ARESET pulsed during W_DATA beat 2 -> all outputs 0 during reset, no B issued, AWREADY=1 on the first cycle after release.
